result_ram_writer: RTL and testbench
====================================

# result_ram_writer

Write-side counterpart of the controller/input register bank read path. Accepts the PE array's output stream one element per handshake. Packs PACK elements into one RAM word. Writes NUM_ROWS words to the result RAM at sequential addresses, then pulses `done`, mirroring how the ROM side fetches operands row by row.

## Interface
Parameters:
- ELEM_WIDTH, 16, width of one result element (2 × operand data width).
- PACK, 4, elements per RAM word; must be ≥ 2.
- ADDR_WIDTH, 8, RAM address width.
- NUM_ROWS, 16, RAM words per job; must be 1 … 2^ADDR_WIDTH.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; high in IDLE starts a job; low mid-job aborts.
- in_valid  in  1  producer has an element on in_data.
- in_data  in  ELEM_WIDTH  result element.
- in_ready  out  1  block can accept an element this cycle.
- ram_we  out  1  one-cycle write strobe.
- ram_address  out  ADDR_WIDTH  write address.
- ram_data  out  ELEM_WIDTH*PACK  packed word; lane 0 in LSBs.
- busy  out  1  high in COLLECT and WRITE.
- done  out  1  one-cycle pulse after the last row is written.

## Operation
- State machine: IDLE, COLLECT, WRITE, DONE. All outputs are registered or decoded from registered state only; no combinational path from in_valid to in_ready.
- **IDLE:**
  - in_ready=0.
  - If enable=1, go to COLLECT and clear lane_cnt, row_cnt and the pack register.
- **COLLECT:**
  - in_ready=1.
  - An element is accepted on a cycle where in_valid && in_ready. It is stored in lane lane_cnt, i.e. bits [lane_cnt*ELEM_WIDTH +: ELEM_WIDTH], and lane_cnt increments.
  - When the accepted element is lane PACK-1, lane_cnt wraps to 0 and the state goes to WRITE.
  - in_valid low: hold all state; no timeout.
- **WRITE:**
  - in_ready=0 and ram_we=1 for exactly this cycle.
  - ram_address=row_cnt; ram_data holds the packed word.
  - If row_cnt==NUM_ROWS-1, go to DONE. Otherwise increment row_cnt and go to COLLECT.
- **DONE:**
  - done=1 for one cycle, then go to IDLE.
  - If enable is still high in IDLE, a new job starts; enable is level, not edge.
- **Abort:**
  - enable=0 in COLLECT goes to IDLE next cycle. Any partial row is discarded: no ram_we, no done.
  - Any element accepted in that same cycle is dropped.
  - enable in WRITE and DONE is ignored, so the current row completes.
- ram_address and ram_data hold their last values outside WRITE. RAM writes are qualified only by ram_we.
- No arithmetic on the data; the counters are plain binary. row_cnt never exceeds NUM_ROWS-1, so there is no address wrap within a job.

## Timing
- Reset values: in_ready=0, ram_we=0, ram_address=0, ram_data=0, busy=0, done=0. State is IDLE and all counters are 0.
- Reset asserted mid-job returns to IDLE immediately (asynchronously). No write or done is emitted afterwards.
- Start: enable sampled high at edge N gives in_ready=1 from cycle N+1.
- ram_we is asserted in the cycle after the edge that accepts lane PACK-1.
- Throughput is PACK+1 cycles per row with in_valid held high. A full job takes NUM_ROWS*(PACK+1) cycles plus 1 done cycle.
- done rises one cycle after the final ram_we. busy falls in that same cycle.

## Test plan
- **Reset values:** assert reset for 3 cycles with random inputs -> all outputs 0; in_ready stays 0 while enable=0.
- **Full job, continuous stream:** PACK=4, NUM_ROWS=2, enable=1, in_valid held, in_data=1,2,3,…,8 ->
  - ram_we at addr 0 with data 0x0004_0003_0002_0001;
  - then ram_we at addr 1 with data 0x0008_0007_0006_0005;
  - done 1 cycle after the second write; 10 cycles from first in_ready to done.
- **Bubbles:** in_valid toggles 1,0,1,0 -> identical RAM contents to the continuous case; ram_we count=NUM_ROWS; no element accepted while in_ready=0.
- **Abort:** drop enable after 2 elements of row 1 -> no ram_we for row 1 and no done; next enable restarts at addr 0 with lane 0.
- **Async reset mid-WRITE:** pulse reset between clock edges during WRITE -> ram_we falls immediately, no done; restart writes from addr 0.
- **Back-to-back jobs:** enable held high through DONE -> second job starts in the cycle after done, addr restarts at 0, done pulses exactly once per job.

Source files
------------

// File: rtl/result_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : result_ram_writer
// Description : Collects the PE array result stream one element per
//               handshake, packs PACK elements into one RAM word and writes
//               NUM_ROWS words to sequential addresses, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module result_ram_writer #(
    parameter int ELEM_WIDTH = 16,
    parameter int PACK       = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_ROWS   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           in_valid,
    input  logic [ELEM_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_address,
    output logic [ELEM_WIDTH*PACK-1:0]     ram_data,
    output logic                           busy,
    output logic                           done
);

    localparam int c_lane_w = $clog2(PACK);
    localparam logic [c_lane_w-1:0]   c_last_lane = c_lane_w'(PACK - 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_row  = ADDR_WIDTH'(NUM_ROWS - 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_collect = 2'd1;
    localparam logic [1:0] c_write   = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    logic [1:0]                 r_state;
    logic [1:0]                 w_next_state;
    logic [c_lane_w-1:0]        r_lane_cnt;
    logic [ADDR_WIDTH-1:0]      r_row_cnt;
    logic [ELEM_WIDTH*PACK-1:0] r_pack;
    logic [ELEM_WIDTH*PACK-1:0] w_merged;
    logic [ADDR_WIDTH-1:0]      r_ram_address;
    logic [ELEM_WIDTH*PACK-1:0] r_ram_data;
    logic                       w_accept;
    logic                       w_last_lane;
    logic                       w_last_row;

    // An element lands only while collecting and the job is still enabled;
    // an element offered in the abort cycle is dropped.
    assign w_accept    = (r_state == c_collect) && in_valid && enable;
    assign w_last_lane = (r_lane_cnt == c_last_lane);
    assign w_last_row  = (r_row_cnt == c_last_row);

    // Pack register with the incoming element merged into the current lane.
    always_comb begin
        w_merged = r_pack;
        for (int i = 0; i < PACK; i++) begin
            if (r_lane_cnt == c_lane_w'(i)) begin
                w_merged[i*ELEM_WIDTH +: ELEM_WIDTH] = in_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; enable is only honoured in IDLE and COLLECT so a
    // row that has reached WRITE always completes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (enable) w_next_state = c_collect;
            end
            c_collect: begin
                if (!enable)                       w_next_state = c_idle;
                else if (in_valid && w_last_lane)  w_next_state = c_write;
            end
            c_write: begin
                w_next_state = w_last_row ? c_done : c_collect;
            end
            c_done: begin
                w_next_state = c_idle;
            end
            default: w_next_state = c_idle;
        endcase
    end

    // Status outputs decoded purely from the registered state.
    always_comb begin
        in_ready = 1'b0;
        ram_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            c_collect: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            c_write: begin
                ram_we = 1'b1;
                busy   = 1'b1;
            end
            c_done: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters, pack register and the held RAM address/data. The RAM word is
    // captured on the edge that accepts the last lane so it is valid during
    // WRITE and keeps its value afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane_cnt    <= '0;
            r_row_cnt     <= '0;
            r_pack        <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (enable) begin
                        r_lane_cnt <= '0;
                        r_row_cnt  <= '0;
                        r_pack     <= '0;
                    end
                end
                c_collect: begin
                    if (w_accept) begin
                        r_pack <= w_merged;
                        if (w_last_lane) begin
                            r_lane_cnt    <= '0;
                            r_ram_data    <= w_merged;
                            r_ram_address <= r_row_cnt;
                        end else begin
                            r_lane_cnt <= r_lane_cnt + c_lane_w'(1);
                        end
                    end
                end
                c_write: begin
                    if (!w_last_row) r_row_cnt <= r_row_cnt + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;

endmodule
`default_nettype wire

// File: tb/tb_result_ram_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_result_ram_writer
// Description : Directed self-checking bench for result_ram_writer with
//               PACK=4, NUM_ROWS=2, ELEM_WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_ram_writer;

    localparam int ELEM_WIDTH = 16;
    localparam int PACK       = 4;
    localparam int ADDR_WIDTH = 8;
    localparam int NUM_ROWS   = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       enable;
    logic                       in_valid;
    logic [ELEM_WIDTH-1:0]      in_data;
    logic                       in_ready;
    logic                       ram_we;
    logic [ADDR_WIDTH-1:0]      ram_address;
    logic [ELEM_WIDTH*PACK-1:0] ram_data;
    logic                       busy;
    logic                       done;

    int n_checks = 0;
    int n_errors = 0;

    // Write log filled by the monitor.
    logic [ADDR_WIDTH-1:0]      wr_addr [0:63];
    logic [ELEM_WIDTH*PACK-1:0] wr_data [0:63];
    longint                     wr_t    [0:63];
    int                         wr_n    = 0;
    int                         done_n  = 0;

    result_ram_writer #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .PACK       (PACK),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_ROWS   (NUM_ROWS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ram_we      (ram_we),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Log every RAM write and every done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_we && wr_n < 64) begin
            wr_addr[wr_n] <= ram_address;
            wr_data[wr_n] <= ram_data;
            wr_t[wr_n]    <= $time;
            wr_n          <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one job: element k carries base+k+1. Optionally toggles in_valid
    // and optionally drops enable once abort_after elements were accepted.
    task automatic run_job(input int n_elems, input bit bubbles, input int abort_after,
                           input int base, output longint t_ready, output longint t_done);
        int  idx     = 0;
        bit  offered = 1'b0;
        bit  tog     = 1'b1;
        bit  stop    = 1'b0;
        int  guard   = 0;
        t_ready = -1;
        t_done  = -1;
        enable  = 1'b1;
        while (!stop && guard < 300) begin
            @(negedge clk);
            guard++;
            if (offered) idx++;
            if (in_ready && t_ready < 0) t_ready = $time;
            if (done) begin
                t_done = $time;
                stop   = 1'b1;
            end else if (abort_after > 0 && idx == abort_after) begin
                enable   = 1'b0;
                in_valid = 1'b1;
                in_data  = 16'hEEEE;
                @(negedge clk);
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
                stop = 1'b1;
            end else begin
                in_data  = ELEM_WIDTH'(base + idx + 1);
                in_valid = (idx < n_elems) && (!bubbles || tog);
                tog      = !tog;
                offered  = in_ready && in_valid;
            end
        end
        in_valid = 1'b0;
        if (abort_after == 0 && t_done < 0) check_val("job_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        longint t_r, t_d, t_r2, t_d2;
        int     wb, db;
        int     guard;

        // Reset with random inputs.
        reset    = 1'b1;
        enable   = 1'($urandom);
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
        repeat (3) begin
            @(negedge clk);
            enable   = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
        end
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_ram_we",   64'(ram_we),   64'd0);
        check_val("rst_addr",     64'(ram_address), 64'd0);
        check_val("rst_data",     64'(ram_data), 64'd0);
        check_val("rst_busy",     64'(busy),     64'd0);
        check_val("rst_done",     64'(done),     64'd0);
        reset    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_in_ready", 64'(in_ready), 64'd0);
        check_val("idle_busy",     64'(busy),     64'd0);
        in_valid = 1'b0;

        // Full job, continuous stream.
        wb = wr_n; db = done_n;
        run_job(8, 1'b0, 0, 0, t_r, t_d);
        check_val("cont_busy_at_done", 64'(busy), 64'd0);
        enable = 1'b0;
        #1;
        check_val("cont_wr_cnt", 64'(wr_n - wb), 64'd2);
        check_val("cont_addr0",  64'(wr_addr[wb]),   64'd0);
        check_val("cont_data0",  wr_data[wb],        64'h0004_0003_0002_0001);
        check_val("cont_addr1",  64'(wr_addr[wb+1]), 64'd1);
        check_val("cont_data1",  wr_data[wb+1],      64'h0008_0007_0006_0005);
        check_val("cont_done_cnt", 64'(done_n - db), 64'd1);
        check_val("cont_ready_to_done", 64'(t_d - t_r), 64'd100);
        check_val("cont_we_to_done",    64'(t_d - wr_t[wb+1]), 64'd10);
        repeat (2) @(negedge clk);

        // Bubbles: in_valid toggling.
        wb = wr_n; db = done_n;
        run_job(8, 1'b1, 0, 0, t_r, t_d);
        enable = 1'b0;
        #1;
        check_val("bub_wr_cnt", 64'(wr_n - wb), 64'd2);
        check_val("bub_addr0",  64'(wr_addr[wb]),   64'd0);
        check_val("bub_data0",  wr_data[wb],        64'h0004_0003_0002_0001);
        check_val("bub_addr1",  64'(wr_addr[wb+1]), 64'd1);
        check_val("bub_data1",  wr_data[wb+1],      64'h0008_0007_0006_0005);
        check_val("bub_done_cnt", 64'(done_n - db), 64'd1);
        repeat (2) @(negedge clk);

        // Abort after two elements of row 1.
        wb = wr_n; db = done_n;
        run_job(8, 1'b0, 6, 16'h10, t_r, t_d);
        #1;
        check_val("abort_wr_cnt",   64'(wr_n - wb), 64'd1);
        check_val("abort_data0",    wr_data[wb],    64'h0014_0013_0012_0011);
        check_val("abort_done_cnt", 64'(done_n - db), 64'd0);
        check_val("abort_in_ready", 64'(in_ready),  64'd0);
        check_val("abort_busy",     64'(busy),      64'd0);
        wb = wr_n; db = done_n;
        run_job(8, 1'b0, 0, 0, t_r, t_d);
        enable = 1'b0;
        #1;
        check_val("restart_addr0", 64'(wr_addr[wb]), 64'd0);
        check_val("restart_data0", wr_data[wb],      64'h0004_0003_0002_0001);
        check_val("restart_done_cnt", 64'(done_n - db), 64'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset during WRITE.
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0055;
        guard    = 0;
        while (!ram_we && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("arst_reached_write", 64'(ram_we), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_val("arst_ram_we", 64'(ram_we),   64'd0);
        check_val("arst_busy",   64'(busy),     64'd0);
        check_val("arst_data",   64'(ram_data), 64'd0);
        enable   = 1'b0;
        in_valid = 1'b0;
        #1 reset = 1'b0;
        db = done_n;
        repeat (4) @(negedge clk);
        #1;
        check_val("arst_no_done", 64'(done_n - db), 64'd0);
        wb = wr_n;
        run_job(8, 1'b0, 0, 16'h20, t_r, t_d);
        enable = 1'b0;
        #1;
        check_val("arst_restart_addr0", 64'(wr_addr[wb]), 64'd0);
        check_val("arst_restart_data0", wr_data[wb],      64'h0024_0023_0022_0021);
        repeat (2) @(negedge clk);

        // Back-to-back jobs with enable held high.
        wb = wr_n; db = done_n;
        run_job(8, 1'b0, 0, 16'h30, t_r, t_d);
        run_job(8, 1'b0, 0, 16'h40, t_r2, t_d2);
        enable = 1'b0;
        #1;
        check_val("b2b_wr_cnt",   64'(wr_n - wb), 64'd4);
        check_val("b2b_done_cnt", 64'(done_n - db), 64'd2);
        check_val("b2b_restart_gap", 64'(t_r2 - t_d), 64'd20);
        check_val("b2b_j2_addr0", 64'(wr_addr[wb+2]), 64'd0);
        check_val("b2b_j2_data0", wr_data[wb+2],      64'h0044_0043_0042_0041);
        check_val("b2b_j2_addr1", 64'(wr_addr[wb+3]), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check_val("b2b_done_once", 64'(done_n - db), 64'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
